// File: rtl/ex_stage_mdu.sv
`timescale 1ns/1ps
// MIPS execute stage: operand forwarding, single-cycle ALU, iterative unsigned
// multiply/divide with HI/LO, and the EX/MEM pipeline register.
module ex_stage_mdu #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [RA_W-1:0]  rs_num,
    input  logic [RA_W-1:0]  rt_num,
    input  logic [RA_W-1:0]  rd_num,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic             reg_write,
    input  logic             flush,
    input  logic             wb_reg_write,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             stall,
    output logic             exm_valid,
    output logic [WIDTH-1:0] exm_result,
    output logic [WIDTH-1:0] exm_store,
    output logic [RA_W-1:0]  exm_rd,
    output logic             exm_reg_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_MULTU = 4'd6;
    localparam logic [3:0] OP_DIVU = 4'd7;
    localparam logic [3:0] OP_MFHI = 4'd8;
    localparam logic [3:0] OP_MFLO = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   work_hi, work_lo, operand;
    logic               is_div;
    logic [WIDTH-1:0]   fwd_a, fwd_b, alu_b, alu_result;
    logic               is_mdu, accept, last_step;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_fits;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fwd_a = rs_val;
        fwd_b = rt_val;
        if (exm_reg_write && exm_rd == rs_num && rs_num != '0)
            fwd_a = exm_result;
        else if (wb_reg_write && wb_rd == rs_num && rs_num != '0)
            fwd_a = wb_data;
        if (exm_reg_write && exm_rd == rt_num && rt_num != '0)
            fwd_b = exm_result;
        else if (wb_reg_write && wb_rd == rt_num && rt_num != '0)
            fwd_b = wb_data;
    end

    assign alu_b  = alu_src ? imm : fwd_b;
    assign is_mdu = (op == OP_MULTU) || (op == OP_DIVU);
    // Gated by reset so the front of the pipe is released while reset is held.
    assign stall  = rst & in_valid & is_mdu & (state != S_DONE) & ~flush;
    assign accept = in_valid & ~stall & ~flush;

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = fwd_a + alu_b;
            OP_SUB:  alu_result = fwd_a - alu_b;
            OP_AND:  alu_result = fwd_a & alu_b;
            OP_OR:   alu_result = fwd_a | alu_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
            OP_NOR:  alu_result = ~(fwd_a | alu_b);
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, operand};
    assign div_diff  = div_shift - {1'b0, operand};
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid && is_mdu)
                            state_next = (op == OP_DIVU && fwd_b == '0) ? S_DONE : S_RUN;
                S_RUN:  if (last_step) state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid && is_mdu) begin
                    cnt     <= '0;
                    operand <= fwd_b;
                    is_div  <= (op == OP_DIVU);
                    if (op == OP_DIVU && fwd_b == '0) begin
                        work_hi <= fwd_a;
                        work_lo <= '1;
                    end else begin
                        work_hi <= '0;
                        work_lo <= fwd_a;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        work_hi <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], div_fits};
                    end else begin
                        {work_hi, work_lo} <= {mul_sum, work_lo[WIDTH-1:1]};
                    end
                end
                S_DONE: begin
                    hi <= work_hi;
                    lo <= work_lo;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_valid     <= 1'b0;
            exm_result    <= '0;
            exm_store     <= '0;
            exm_rd        <= '0;
            exm_reg_write <= 1'b0;
        end else begin
            exm_valid     <= accept;
            exm_reg_write <= accept & reg_write & ~is_mdu;
            exm_result    <= alu_result;
            exm_store     <= fwd_b;
            exm_rd        <= rd_num;
        end
    end

endmodule
